adder_resp_misr: RTL and testbench
==================================

# adder_resp_misr

Response compactor for the 16-bit adder under test: the observing end of the adder's stimulus/response interface. It samples `{pin_co, pin_sum}` on every valid cycle of a test session and folds each sample into a multiple-input signature register (MISR). After a programmed number of responses it compares the signature with a golden value and reports pass/fail. The block sits beside the adder in the self-test wrapper, opposite the pattern source that drives `pin_a`, `pin_b`, `pin_cin` and `pin_sel`.

## Interface
Parameters:
- `N`, 16: adder data width; the signature is N+1 bits wide.
- `CNT_W`, 8: width of the response counter.
- `POLY`, 17'h04001: Galois feedback taps over bits [N:0] (x^17+x^14+1); must be overridden whenever N≠16.

Ports (all clocked on `pin_clk`):
- `pin_clk` in 1: clock, rising edge.
- `pin_rst` in 1: reset, asynchronous, active-high.
- `pin_start` in 1: session start request, sampled only in IDLE.
- `pin_num` in CNT_W: number of responses to compact, latched at start.
- `pin_seed` in N+1: initial signature, loaded at start.
- `pin_golden` in N+1: expected signature, sampled in CMP.
- `pin_valid` in 1: `pin_sum`/`pin_co` hold a response this cycle.
- `pin_sum` in N: adder sum under observation.
- `pin_co` in 1: adder carry-out under observation.
- `pin_busy` out 1: session in progress (RUN or CMP).
- `pin_done` out 1: one-cycle pulse at session end.
- `pin_pass` out 1: signature matched; held until the next accepted start.
- `pin_sig` out N+1: current signature.
- `pin_cnt` out CNT_W: responses accepted in the current or last session.

## Operation
- Reset values: state=IDLE; `pin_busy`, `pin_done` and `pin_pass` are 0; `pin_sig` and `pin_cnt` are 0.
- States and transitions:
  - IDLE → RUN on `pin_start`: sig←`pin_seed`, cnt←0, num latched, `pin_pass`←0.
  - IDLE → CMP instead when `pin_num`=0; the signature stays equal to seed.
- RUN, with `pin_valid`=1:
  - d = {`pin_co`, `pin_sum`}.
  - sig ← {sig[N-1:0],1'b0} ^ (sig[N] ? POLY : 0) ^ d.
  - cnt ← cnt+1.
- RUN, with `pin_valid`=0: sig and cnt hold.
- RUN → CMP on the edge that accepts response number num.
- CMP → IDLE unconditionally. On that edge: `pin_pass`←(sig==`pin_golden`), `pin_done`←1. `pin_done` clears on the following edge.
- Width rules:
  - The shift discards sig[N]; feedback and XOR are modulo 2; there is no carry.
  - The counter does not wrap, because the session ends at cnt==num ≤ 2^CNT_W−1.
- Boundary conditions:
  - `pin_start` during RUN or CMP is ignored.
  - `pin_start` in the IDLE cycle where `pin_done`=1 is accepted; `pin_pass` clears on the same edge.
  - `pin_valid` in IDLE or CMP is ignored.
  - `pin_golden` changing during RUN has no effect; it is sampled only in CMP.
  - `pin_rst` mid-session: immediate return to reset values; no `pin_done` pulse.

## Timing
- `pin_busy` rises on the edge that samples `pin_start`. It falls on the CMP→IDLE edge, the same edge on which `pin_done` rises.
- Latency: `pin_done` is high during the cycle that follows the CMP cycle, i.e. 2 edges after the last accepted response.
- With num=0, `pin_done` is high 2 edges after start.
- Throughput: one response per cycle; back-to-back valids are all accepted.
- `pin_sig` and `pin_cnt` are registered and update on the accepting edge.

## Configuration
- `ADDER_MISR_ABORT_EN` defined:
  - Adds input `pin_abort` (1 bit).
  - `pin_abort`=1 in RUN moves the block to IDLE on that edge with `pin_done`=1, `pin_pass`=0, and sig/cnt frozen.
  - `pin_abort` has priority over a simultaneous `pin_valid`.
  - In IDLE or CMP, `pin_abort` is ignored.
- `ADDER_MISR_ABORT_EN` undefined: the port is absent and sessions end only by count or reset.

## Test plan
- Single response:
  - Stimulus: seed=0, num=1, valid with sum=16'h000F, co=0, golden=17'h0000F.
  - Required: sig=17'h0000F, `pin_done` pulse 2 edges later, pass=1, cnt=1.
- Two responses with gaps:
  - Stimulus: seed=0, num=2, responses {0,16'hFFFF} then {0,16'h000F}, with idle valid gaps between them.
  - Required: sig=17'h0FFFF, then 17'h1FFF1; golden=17'h1FFF1 gives pass=1; golden=17'h1FFF0 gives pass=0.
- Feedback path:
  - Stimulus: seed=17'h10000, num=1, response 0.
  - Required: sig=17'h04001.
- Degenerate count and ignored start:
  - Stimulus 1: num=0, seed=17'h00123, golden=17'h00123. Required: no valid needed, done 2 edges after start, pass=1.
  - Stimulus 2: `pin_start` pulsed mid-RUN. Required: session unaffected.
- Reset mid-session:
  - Stimulus: assert `pin_rst` after 1 of 3 responses.
  - Required: busy=0, sig=0, cnt=0 and pass=0 immediately; no done pulse.
  - Then: a new session completes normally.
- Abort (only with `ADDER_MISR_ABORT_EN`):
  - Stimulus: abort together with the 2nd valid of 3.
  - Required: done=1, pass=0, cnt=1.

Source files
------------

// File: rtl/adder_resp_misr.sv
// adder_resp_misr: response compactor for the 16-bit adder under test.
// Folds {pin_co, pin_sum} into an (N+1)-bit Galois MISR on every valid cycle.
// After pin_num responses, it compares the signature with pin_golden and
// reports pass/fail.
//
// Optional feature: define ADDER_MISR_ABORT_EN to add pin_abort. This input
// ends a running session early with done=1 and pass=0.
//
// Ports:
//   pin_clk, pin_rst   clock (rising edge), async active-high reset
//   pin_start          session start request, sampled only in IDLE
//   pin_num            responses to compact, latched at start
//   pin_seed           initial signature, loaded at start
//   pin_golden         expected signature, sampled in CMP
//   pin_valid          pin_sum/pin_co carry a response this cycle
//   pin_sum, pin_co    adder response under observation
//   pin_abort          (ADDER_MISR_ABORT_EN only) abandon the running session
//   pin_busy           session in progress (RUN or CMP)
//   pin_done           one-cycle pulse at session end
//   pin_pass           signature matched, held until the next accepted start
//   pin_sig            current signature
//   pin_cnt            responses accepted in the current or last session
module adder_resp_misr #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 8,
  parameter logic [N:0]  POLY  = 17'h04001
) (
  input  logic             pin_clk,
  input  logic             pin_rst,
  input  logic             pin_start,
  input  logic [CNT_W-1:0] pin_num,
  input  logic [N:0]       pin_seed,
  input  logic [N:0]       pin_golden,
  input  logic             pin_valid,
  input  logic [N-1:0]     pin_sum,
  input  logic             pin_co,
`ifdef ADDER_MISR_ABORT_EN
  input  logic             pin_abort,
`endif
  output logic             pin_busy,
  output logic             pin_done,
  output logic             pin_pass,
  output logic [N:0]       pin_sig,
  output logic [CNT_W-1:0] pin_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_q, num_nxt;
  logic [N:0]       sig_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             pass_nxt;

  // One MISR step. The shift drops sig[N], which instead selects the feedback taps.
  logic [N:0]       sig_fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             abort_req;

  assign sig_fold = {pin_sig[N-1:0], 1'b0}
                  ^ (pin_sig[N] ? POLY : (N+1)'(0))
                  ^ {pin_co, pin_sum};
  assign cnt_inc  = pin_cnt + CNT_W'(1);

`ifdef ADDER_MISR_ABORT_EN
  assign abort_req = pin_abort;
`else
  assign abort_req = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      state    <= IDLE;
      num_q    <= '0;
      pin_sig  <= '0;
      pin_cnt  <= '0;
      pin_busy <= 1'b0;
      pin_done <= 1'b0;
      pin_pass <= 1'b0;
    end else begin
      state    <= state_nxt;
      num_q    <= num_nxt;
      pin_sig  <= sig_nxt;
      pin_cnt  <= cnt_nxt;
      pin_busy <= busy_nxt;
      pin_done <= done_nxt;
      pin_pass <= pass_nxt;
    end
  end

  // Next-state and next-output logic. pin_done defaults low, so it pulses for one cycle.
  always_comb begin
    state_nxt = state;
    num_nxt   = num_q;
    sig_nxt   = pin_sig;
    cnt_nxt   = pin_cnt;
    busy_nxt  = pin_busy;
    done_nxt  = 1'b0;
    pass_nxt  = pin_pass;

    unique case (state)
      IDLE: begin
        if (pin_start) begin
          num_nxt   = pin_num;
          sig_nxt   = pin_seed;
          cnt_nxt   = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          // With a zero count there is nothing to compact; the signature is compared as seeded.
          state_nxt = (pin_num == '0) ? CMP : RUN;
        end
      end

      RUN: begin
        if (abort_req) begin
          // Abort outranks a simultaneous valid. sig and cnt stay frozen.
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b0;
        end else if (pin_valid) begin
          sig_nxt = sig_fold;
          cnt_nxt = cnt_inc;
          if (cnt_inc == num_q) begin
            state_nxt = CMP;
          end
        end
      end

      CMP: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        pass_nxt  = (pin_sig == pin_golden);
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_resp_misr.sv
// Directed self-checking bench for adder_resp_misr.
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, before the next edge.
module tb_adder_resp_misr;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 8;

  logic             pin_clk = 1'b0;
  logic             pin_rst;
  logic             pin_start;
  logic [CNT_W-1:0] pin_num;
  logic [N:0]       pin_seed;
  logic [N:0]       pin_golden;
  logic             pin_valid;
  logic [N-1:0]     pin_sum;
  logic             pin_co;
`ifdef ADDER_MISR_ABORT_EN
  logic             pin_abort;
`endif
  logic             pin_busy;
  logic             pin_done;
  logic             pin_pass;
  logic [N:0]       pin_sig;
  logic [CNT_W-1:0] pin_cnt;

  int checks   = 0;
  int failures = 0;

  adder_resp_misr #(.N(N), .CNT_W(CNT_W), .POLY(17'h04001)) dut (
    .pin_clk    (pin_clk),
    .pin_rst    (pin_rst),
    .pin_start  (pin_start),
    .pin_num    (pin_num),
    .pin_seed   (pin_seed),
    .pin_golden (pin_golden),
    .pin_valid  (pin_valid),
    .pin_sum    (pin_sum),
    .pin_co     (pin_co),
`ifdef ADDER_MISR_ABORT_EN
    .pin_abort  (pin_abort),
`endif
    .pin_busy   (pin_busy),
    .pin_done   (pin_done),
    .pin_pass   (pin_pass),
    .pin_sig    (pin_sig),
    .pin_cnt    (pin_cnt)
  );

  always #5 pin_clk = ~pin_clk;

  task automatic tick();
    @(posedge pin_clk);
    #1;
  endtask

  task automatic idle_inputs();
    pin_start = 1'b0;
    pin_valid = 1'b0;
    pin_sum   = '0;
    pin_co    = 1'b0;
`ifdef ADDER_MISR_ABORT_EN
    pin_abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    pin_rst    = 1'b1;
    pin_num    = '0;
    pin_seed   = '0;
    pin_golden = '0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({pin_busy, pin_done, pin_pass} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags busy/done/pass got %b expected 000", {pin_busy, pin_done, pin_pass});
    end
    checks++;
    if (pin_sig !== 17'h0 || pin_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_sig_cnt got sig=%h cnt=%0d expected sig=00000 cnt=0", pin_sig, pin_cnt);
    end
    pin_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    pin_start = 1'b1; pin_num = 8'd1; pin_seed = 17'h0;
    tick();
    checks++;
    if (pin_busy !== 1'b1 || pin_sig !== 17'h0 || pin_cnt !== 8'd0) begin
      failures++;
      $display("FAIL single_start got busy=%b sig=%h cnt=%0d expected busy=1 sig=00000 cnt=0", pin_busy, pin_sig, pin_cnt);
    end
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h000F; pin_co = 1'b0;
    tick();
    checks++;
    if (pin_sig !== 17'h0000F || pin_cnt !== 8'd1 || pin_done !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got sig=%h cnt=%0d done=%b expected sig=0000f cnt=1 done=0", pin_sig, pin_cnt, pin_done);
    end
    idle_inputs(); pin_golden = 17'h0000F;
    tick();
    checks++;
    if (pin_done !== 1'b1 || pin_pass !== 1'b1 || pin_busy !== 1'b0 || pin_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_done got done=%b pass=%b busy=%b cnt=%0d expected 1 1 0 1", pin_done, pin_pass, pin_busy, pin_cnt);
    end
    tick();
    checks++;
    if (pin_done !== 1'b0 || pin_pass !== 1'b1) begin
      failures++;
      $display("FAIL single_done_clear got done=%b pass=%b expected done=0 pass=1", pin_done, pin_pass);
    end
  endtask

  // Two sessions back to back. The second starts in the done cycle of the
  // first and uses a wrong golden value.
  task automatic test_two_gaps();
    logic [N:0] goldens [2];
    logic       exp_pass [2];
    goldens[0] = 17'h1FFF1; exp_pass[0] = 1'b1;
    goldens[1] = 17'h1FFF0; exp_pass[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pin_start = 1'b1; pin_num = 8'd2; pin_seed = 17'h0;
      tick();
      checks++;
      if (pin_busy !== 1'b1 || pin_pass !== 1'b0 || pin_done !== 1'b0) begin
        failures++;
        $display("FAIL two_start%0d got busy=%b pass=%b done=%b expected 1 0 0", s, pin_busy, pin_pass, pin_done);
      end
      pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'hFFFF; pin_co = 1'b0;
      tick();
      pin_valid = 1'b0; pin_sum = 16'h5555; pin_co = 1'b1;
      tick();
      tick();
      checks++;
      if (pin_sig !== 17'h0FFFF || pin_cnt !== 8'd1) begin
        failures++;
        $display("FAIL two_first%0d got sig=%h cnt=%0d expected sig=0ffff cnt=1", s, pin_sig, pin_cnt);
      end
      pin_valid = 1'b1; pin_sum = 16'h000F; pin_co = 1'b0;
      pin_golden = 17'h00BAD;
      tick();
      checks++;
      if (pin_sig !== 17'h1FFF1 || pin_cnt !== 8'd2) begin
        failures++;
        $display("FAIL two_second%0d got sig=%h cnt=%0d expected sig=1fff1 cnt=2", s, pin_sig, pin_cnt);
      end
      // A valid and a start in CMP must both be ignored.
      pin_valid = 1'b1; pin_sum = 16'h1234; pin_start = 1'b1;
      pin_golden = goldens[s];
      tick();
      checks++;
      if (pin_done !== 1'b1 || pin_pass !== exp_pass[s] || pin_busy !== 1'b0 || pin_sig !== 17'h1FFF1) begin
        failures++;
        $display("FAIL two_done%0d got done=%b pass=%b busy=%b sig=%h expected 1 %b 0 1fff1", s, pin_done, pin_pass, pin_busy, pin_sig, exp_pass[s]);
      end
      idle_inputs();
    end
    tick();
  endtask

  task automatic test_feedback();
    pin_start = 1'b1; pin_num = 8'd1; pin_seed = 17'h10000;
    tick();
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h0; pin_co = 1'b0;
    tick();
    checks++;
    if (pin_sig !== 17'h04001) begin
      failures++;
      $display("FAIL feedback got sig=%h expected 04001", pin_sig);
    end
    idle_inputs(); pin_golden = 17'h04001;
    tick();
    tick();
  endtask

  task automatic test_num_zero();
    pin_start = 1'b1; pin_num = 8'd0; pin_seed = 17'h00123; pin_golden = 17'h00123;
    tick();
    pin_start = 1'b0;
    checks++;
    if (pin_busy !== 1'b1 || pin_sig !== 17'h00123 || pin_done !== 1'b0) begin
      failures++;
      $display("FAIL zero_start got busy=%b sig=%h done=%b expected 1 00123 0", pin_busy, pin_sig, pin_done);
    end
    tick();
    checks++;
    if (pin_done !== 1'b1 || pin_pass !== 1'b1 || pin_cnt !== 8'd0) begin
      failures++;
      $display("FAIL zero_done got done=%b pass=%b cnt=%0d expected 1 1 0", pin_done, pin_pass, pin_cnt);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    pin_start = 1'b1; pin_num = 8'd2; pin_seed = 17'h0;
    tick();
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h0001;
    tick();
    // A start mid-RUN with a different seed and count must change nothing.
    pin_valid = 1'b0; pin_start = 1'b1; pin_num = 8'd0; pin_seed = 17'h1FFFF;
    tick();
    checks++;
    if (pin_sig !== 17'h00001 || pin_cnt !== 8'd1 || pin_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_start got sig=%h cnt=%0d busy=%b expected 00001 1 1", pin_sig, pin_cnt, pin_busy);
    end
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h0002;
    tick();
    checks++;
    if (pin_sig !== 17'h00000 || pin_cnt !== 8'd2) begin
      failures++;
      $display("FAIL midrun_finish got sig=%h cnt=%0d expected 00000 2", pin_sig, pin_cnt);
    end
    idle_inputs(); pin_golden = 17'h0;
    tick();
    checks++;
    if (pin_done !== 1'b1 || pin_pass !== 1'b1) begin
      failures++;
      $display("FAIL midrun_done got done=%b pass=%b expected 1 1", pin_done, pin_pass);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    pin_start = 1'b1; pin_num = 8'd3; pin_seed = 17'h00005;
    tick();
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h0001;
    tick();
    idle_inputs();
    checks++;
    if (pin_sig !== 17'h0000B || pin_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rstmid_pre got sig=%h cnt=%0d expected 0000b 1", pin_sig, pin_cnt);
    end
    #2 pin_rst = 1'b1;
    #1;
    checks++;
    if (pin_busy !== 1'b0 || pin_sig !== 17'h0 || pin_cnt !== 8'd0 || pin_pass !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got busy=%b sig=%h cnt=%0d pass=%b expected 0 00000 0 0", pin_busy, pin_sig, pin_cnt, pin_pass);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) pin_rst = 1'b0;
      if (pin_done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL rstmid_nodone got %0d done cycles expected 0", done_seen);
    end
    // A fresh session after the reset: co=1 lands in sig[16].
    pin_start = 1'b1; pin_num = 8'd1; pin_seed = 17'h0;
    tick();
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h1234; pin_co = 1'b1;
    tick();
    idle_inputs(); pin_golden = 17'h11234;
    tick();
    checks++;
    if (pin_done !== 1'b1 || pin_pass !== 1'b1 || pin_sig !== 17'h11234 || pin_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rstmid_after got done=%b pass=%b sig=%h cnt=%0d expected 1 1 11234 1", pin_done, pin_pass, pin_sig, pin_cnt);
    end
    tick();
  endtask

`ifdef ADDER_MISR_ABORT_EN
  task automatic test_abort();
    pin_start = 1'b1; pin_num = 8'd3; pin_seed = 17'h0;
    tick();
    pin_start = 1'b0; pin_valid = 1'b1; pin_sum = 16'h0003;
    tick();
    pin_sum = 16'h0005; pin_abort = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (pin_done !== 1'b1 || pin_pass !== 1'b0 || pin_cnt !== 8'd1 || pin_sig !== 17'h00003 || pin_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort got done=%b pass=%b cnt=%0d sig=%h busy=%b expected 1 0 1 00003 0", pin_done, pin_pass, pin_cnt, pin_sig, pin_busy);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_gaps();
    test_feedback();
    test_num_zero();
    test_ignored_start();
    test_reset_mid();
`ifdef ADDER_MISR_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
